shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier_pkg.sv | 16 +
 rtl/n_bit_adder.sv | 23 ++
 rtl/shift_add_multiplier.sv | 94 +++++++++
 tb/tb_shift_add_multiplier.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and
// the iteration counter width helper.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the value N itself, hence N+1 codes.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/n_bit_adder.sv
// Combinational n-bit ripple-carry adder with carry-in and carry-out.
module n_bit_adder #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         c_in,
    output logic [n-1:0] s,
    output logic         c_out
);

    logic [n:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < n; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign c_out = c[n];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-and-add multiplier around one ripple adder;
// start/busy/done handshake, 2N-bit product registered on entry to DONE.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = count_width(N);

    state_t          state, state_next;
    logic [N-1:0]    a_reg, a_next;
    logic [N-1:0]    q_reg, q_next;
    logic [N-1:0]    m_reg;
    logic [CW-1:0]   count, count_next;
    logic [N-1:0]    addend;
    logic [N-1:0]    sum;
    logic            c_out;

    assign addend = q_reg[0] ? m_reg : '0;

    n_bit_adder #(.n(N)) u_adder (
        .x     (a_reg),
        .y     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (c_out)
    );

    // The carry-out becomes A's MSB; the bit above it always shifts in as 0,
    // so the C register never holds anything but zero and needs no flop.
    always_comb begin
        state_next = state;
        a_next     = a_reg;
        q_next     = q_reg;
        count_next = count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    a_next     = '0;
                    q_next     = b;
                    count_next = CW'(N);
                end
            end
            RUN: begin
                a_next     = {c_out, sum[N-1:1]};
                q_next     = {sum[0], q_reg[N-1:1]};
                count_next = count - 1'b1;
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            a_reg <= a_next;
            q_reg <= q_next;
            count <= count_next;
            if (state == IDLE && start) begin
                m_reg <= a;
            end
            // Capture the final shifted value on the edge that enters DONE.
            if (state == RUN && state_next == DONE) begin
                product <= {a_next, q_next};
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed handshake/latency/reset tests on N=4 plus an
// exhaustive N=4 sweep and random N=8 pairs, checked through scoreboards.
module tb_shift_add_multiplier;

    localparam int unsigned N4 = 4;
    localparam int unsigned N8 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            start4 = 1'b0, busy4, done4;
    logic [N4-1:0]   a4 = '0, b4 = '0;
    logic [2*N4-1:0] product4;

    logic            start8 = 1'b0, busy8, done8;
    logic [N8-1:0]   a8 = '0, b8 = '0;
    logic [2*N8-1:0] product8;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb4[$];
    logic [63:0] sb8[$];
    int acc4 = 0, acc8 = 0;
    int done_cnt4 = 0, done_cnt8 = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.N(N4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .busy    (busy4),
        .done    (done4),
        .product (product4)
    );

    shift_add_multiplier #(.N(N8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: each done pulse pops one expected product.
    always @(negedge clk) begin
        if (!rst && done4) begin
            done_cnt4++;
            check("done4_pending", 64'(sb4.size() != 0), 64'd1);
            if (sb4.size() != 0) check("product4", 64'(product4), sb4.pop_front());
        end
        if (!rst && done8) begin
            done_cnt8++;
            check("done8_pending", 64'(sb8.size() != 0), 64'd1);
            if (sb8.size() != 0) check("product8", 64'(product8), sb8.pop_front());
        end
    end

    task automatic start_mul4(input logic [N4-1:0] x, input logic [N4-1:0] y);
        @(negedge clk);
        a4 = x; b4 = y; start4 = 1'b1;
        @(posedge clk);
        sb4.push_back(64'(x) * 64'(y));
        acc4++;
        #1 start4 = 1'b0;
    endtask

    task automatic start_mul8(input logic [N8-1:0] x, input logic [N8-1:0] y);
        @(negedge clk);
        a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk);
        sb8.push_back(64'(x) * 64'(y));
        acc8++;
        #1 start8 = 1'b0;
    endtask

    task automatic drain4(input string tag);
        int t = 0;
        while (sb4.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(sb4.size()), 64'd0);
    endtask

    task automatic drain8(input string tag);
        int t = 0;
        while (sb8.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(sb8.size()), 64'd0);
    endtask

    // Observe the N+2 cycles following an accepted start edge.
    task automatic measure4(output int busy_n, output int done_at, input bit drop_start);
        busy_n = 0;
        done_at = 0;
        for (int k = 1; k <= int'(N4) + 2; k++) begin
            @(negedge clk);
            if (busy4) busy_n++;
            if (done4 && done_at == 0) done_at = k;
            if (drop_start && k == int'(N4) + 1) start4 = 1'b0;
        end
    endtask

    initial begin
        int busy_n, done_at;

        #2;
        check("reset_busy4", 64'(busy4), 64'd0);
        check("reset_done4", 64'(done4), 64'd0);
        check("reset_product4", 64'(product4), 64'd0);
        check("reset_product8", 64'(product8), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic multiply with latency and busy-width checks
        start_mul4(4'd3, 4'd5);
        measure4(busy_n, done_at, 1'b0);
        check("t1_busy_cycles", 64'(busy_n), 64'(N4));
        check("t1_done_cycle", 64'(done_at), 64'(N4 + 1));
        check("t1_drained", 64'(sb4.size()), 64'd0);

        // Carry-heavy and zero operands
        start_mul4(4'd15, 4'd15); drain4("t2_ff");
        start_mul4(4'd0, 4'd9);   drain4("t2_0x9");
        start_mul4(4'd9, 4'd0);   drain4("t2_9x0");

        // Start during RUN/DONE is ignored; operands churn after acceptance
        start_mul4(4'd7, 4'd6);
        for (int k = 1; k <= int'(N4) + 2; k++) begin
            @(negedge clk);
            start4 = (k <= int'(N4));
            a4 = 4'($urandom);
            b4 = 4'($urandom);
        end
        start4 = 1'b0;
        repeat (10) @(negedge clk);
        check("t3_drained", 64'(sb4.size()), 64'd0);
        check("t3_done_count", 64'(done_cnt4), 64'(acc4));

        // Continuous start: one result every N+2 cycles
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            sb4.push_back(64'd15);
            acc4++;
            measure4(busy_n, done_at, r == 2);
            check("t4_busy_cycles", 64'(busy_n), 64'(N4));
            check("t4_done_cycle", 64'(done_at), 64'(N4 + 1));
        end
        start4 = 1'b0;
        drain4("t4_drained");

        // Asynchronous reset in the second RUN cycle aborts the operation
        start_mul4(4'd12, 4'd11);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_busy_rst", 64'(busy4), 64'd0);
        check("t5_done_rst", 64'(done4), 64'd0);
        check("t5_product_rst", 64'(product4), 64'd0);
        void'(sb4.pop_back());
        acc4--;
        @(negedge clk);
        rst = 1'b0;
        start_mul4(4'd2, 4'd3);
        measure4(busy_n, done_at, 1'b0);
        check("t5_done_cycle", 64'(done_at), 64'(N4 + 1));
        check("t5_drained", 64'(sb4.size()), 64'd0);

        // Exhaustive N=4 sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                start_mul4(4'(i), 4'(j));
                drain4("t6_sweep4");
            end
        end

        // Random N=8 pairs, including the extreme corner
        start_mul8(8'd255, 8'd255);
        drain8("t6_ff8");
        for (int i = 0; i < 1000; i++) begin
            start_mul8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            drain8("t6_rand8");
        end

        repeat (5) @(negedge clk);
        check("final_done_count4", 64'(done_cnt4), 64'(acc4));
        check("final_done_count8", 64'(done_cnt8), 64'(acc8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
